// File: rtl/qtable_port_arbiter.sv
// qtable_port_arbiter
//   Shares the single read/write port of the Q-table RAM between NUM_REQ
//   requesters (learner update, greedy readout, host/debug). Round-robin
//   arbitration, one access per cycle, with a per-requester lock that makes
//   a read-modify-write of one Q entry atomic. The lock is revoked after
//   LOCK_TIMEOUT locked cycles without an owner access.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   req/req_we/req_lock     per-requester request, write flag, keep-lock flag
//   req_addr/req_wdata      packed per-requester address / write data
//   gnt                     one-hot grant, combinational, same cycle as access
//   rvalid/rdata            read return, one cycle after a granted read
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   RAM port (1-cycle read)
//   lock_owner              {lock held, owner index}
//   addr_err/lock_err       one-cycle error pulses
module qtable_port_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ADDR_W       = 7,
    parameter int DATA_W       = 16,
    parameter int DEPTH        = 100,
    parameter int LOCK_TIMEOUT = 15
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ-1:0]            req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rvalid,
    output logic [DATA_W-1:0]             rdata,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic [$clog2(NUM_REQ):0]      lock_owner,
    output logic                          addr_err,
    output logic                          lock_err
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

    logic [NUM_REQ-1:0][ADDR_W-1:0] addr_a;
    logic [NUM_REQ-1:0][DATA_W-1:0] wdata_a;

    genvar g;
    generate
        for (g = 0; g < NUM_REQ; g++) begin : g_unpack
            assign addr_a[g]  = req_addr[g*ADDR_W +: ADDR_W];
            assign wdata_a[g] = req_wdata[g*DATA_W +: DATA_W];
        end
    endgenerate

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] lock_idx;
    logic             lock_held;
    logic [CNT_W-1:0] to_cnt;
    logic             rd_zero;

    logic [IDX_W-1:0]  sel;
    logic              any_gnt;
    logic              sel_ok;
    logic              sel_rd;
    logic [ADDR_W-1:0] sel_addr;

    // Grant selection. While locked only the owner can win. Otherwise scan
    // offsets from rr_ptr in descending order so the smallest offset (the
    // first requester at or after rr_ptr) is the last to write and wins.
    always_comb begin
        any_gnt = 1'b0;
        sel     = rr_ptr;
        if (lock_held) begin
            sel     = lock_idx;
            any_gnt = req[lock_idx];
        end else begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                if (req[IDX_W'((32'(rr_ptr) + 32'(k)) % NUM_REQ)]) begin
                    any_gnt = 1'b1;
                    sel     = IDX_W'((32'(rr_ptr) + 32'(k)) % NUM_REQ);
                end
            end
        end
        if (!reset_n) any_gnt = 1'b0;
    end

    assign sel_addr = addr_a[sel];
    assign sel_ok   = 32'(sel_addr) < DEPTH;
    assign sel_rd   = any_gnt & ~req_we[sel];

    assign gnt       = any_gnt ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << sel) : '0;
    // An illegal address still consumes the slot but never reaches the RAM.
    assign mem_en    = any_gnt & sel_ok;
    assign mem_we    = mem_en & req_we[sel];
    assign mem_addr  = mem_en ? sel_addr : '0;
    assign mem_wdata = mem_en ? wdata_a[sel] : '0;

    assign rdata      = rd_zero ? '0 : mem_rdata;
    assign lock_owner = lock_held ? {1'b1, lock_idx} : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr    <= '0;
            lock_idx  <= '0;
            lock_held <= 1'b0;
            to_cnt    <= '0;
            rvalid    <= '0;
            rd_zero   <= 1'b0;
            addr_err  <= 1'b0;
            lock_err  <= 1'b0;
        end else begin
            rvalid   <= sel_rd ? gnt : '0;
            rd_zero  <= sel_rd & ~sel_ok;
            addr_err <= any_gnt & ~sel_ok;
            lock_err <= 1'b0;
            if (!lock_held) begin
                to_cnt <= '0;
                if (any_gnt) begin
                    rr_ptr <= (sel == IDX_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
                    if (req_lock[sel]) begin
                        lock_held <= 1'b1;
                        lock_idx  <= sel;
                    end
                end
            end else if (any_gnt) begin
                // Owner access: keep the lock only if it asks again.
                to_cnt <= '0;
                if (!req_lock[sel]) lock_held <= 1'b0;
            end else if (to_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                // This is the LOCK_TIMEOUT-th idle locked cycle: revoke.
                to_cnt    <= '0;
                lock_held <= 1'b0;
                lock_err  <= 1'b1;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/qtable_port_arbiter.md
Name: qtable_port_arbiter

Overview:
- Shares the single read/write port of the Q-table RAM (5x5 grid x 4 actions = 100 entries of 16-bit signed Q) between NUM_REQ requesters: learner update engine, greedy-policy readout, host/debug.
- Round-robin arbitration, one access per cycle.
- Lock mechanism makes a requester's read-modify-write of one Q entry atomic.
- Sits between the requesters and the Q-table RAM; the RAM has 1-cycle read latency.

Parameters:
- NUM_REQ, 4, number of requesters.
- ADDR_W, 7, Q-table address width; address = ((x*5)+y)*4+action.
- DATA_W, 16, Q-value width (two's complement).
- DEPTH, 100, number of valid entries; addresses >= DEPTH are illegal.
- LOCK_TIMEOUT, 15, idle cycles a lock owner may go without a granted access before the lock is revoked.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester request.
- req_we  in  NUM_REQ  1=write, 0=read.
- req_lock  in  NUM_REQ  hold exclusive access after this access.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data.
- gnt  out  NUM_REQ  one-hot grant, same cycle as the access.
- rvalid  out  NUM_REQ  read data valid, one cycle after a granted read.
- rdata  out  DATA_W  read data, shared by all requesters; qualified by rvalid.
- mem_en  out  1  RAM access enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_en with mem_we=0.
- lock_owner  out  $clog2(NUM_REQ)+1  MSB=lock held, LSBs=owner index.
- addr_err  out  1  one-cycle pulse on a granted illegal address.
- lock_err  out  1  one-cycle pulse on lock timeout revocation.

Behaviour:
- Reset (async assert, sync release):
  - rr_ptr=0, lock cleared, timeout counter=0.
  - rvalid, addr_err, lock_err = 0.
  - gnt and mem_en are forced to 0 while reset_n=0.
- Handshake:
  - Requester holds req and its command stable until it sees gnt high at a clock edge.
  - It may present a new command in the following cycle.
- gnt, mem_en, mem_we, mem_addr and mem_wdata are combinational from req, rr_ptr and lock state. Zero-latency grant gives full throughput.
- Arbitration (no lock held):
  - Grant the first asserted req scanning from index rr_ptr upward, with wrap-around.
  - After a grant to i, rr_ptr <= (i+1) mod NUM_REQ.
  - If no req is asserted, rr_ptr is unchanged.
- Locked state:
  - Only lock_owner's index may be granted; other requests wait with gnt=0.
  - rr_ptr is frozen while locked.
- Lock set: on a granted access with req_lock=1 from requester i, lock held and owner=i from the next cycle.
- Lock release: on a granted owner access with req_lock=0. That access still completes, and arbitration is open from the next cycle.
- Lock timeout:
  - The counter increments each locked cycle without an owner grant and is cleared on an owner grant.
  - When the counter reaches LOCK_TIMEOUT, the lock is released that edge and lock_err pulses one cycle.
  - The owner's later access is arbitrated normally.
- Read return: rvalid[i] is registered, asserted exactly one cycle after the read grant; rdata = mem_rdata in that cycle.
- Illegal address (req_addr >= DEPTH):
  - The grant is issued and consumes the slot; mem_en=0 that cycle; addr_err pulses the next cycle.
  - For a read, rvalid still pulses with rdata forced to 0. For a write, nothing is written.
  - Lock set/release rules apply unchanged.
- Unselected memory outputs: when mem_en=0, mem_we=0, and mem_addr/mem_wdata are held at 0.
- Back-to-back operation:
  - A write followed by a read of the same address in consecutive cycles returns the new value; the RAM is write-first and the arbiter adds no reordering.
  - rvalid pulses from consecutive grants may be adjacent.
- Reset mid-operation:
  - Any pending rvalid is dropped and the lock is cleared.
  - Requesters must reissue after reset_n rises.

Test Plan:
- All 4 req held high with reads to addresses 0,1,2,3 -> gnt sequence 0001,0010,0100,1000,0001; mem_addr matches; rvalid[i] one cycle after each grant.
- Requester 0 issues a locked read of addr 37, req 1 and 2 high throughout, then 3 cycles later an unlocked write of 37 with Q+5 -> gnt[1], gnt[2] stay 0 until the write grant; lock_owner = 3'b100 during the lock; the next grant goes to 1.
- Requester 2 takes the lock, then idles for 15 cycles -> lock_err pulses once at the 15th idle cycle; lock_owner MSB=0; a pending req 3 is granted the next cycle.
- Read of addr 100 by requester 1 -> gnt[1]=1, mem_en=0; next cycle addr_err=1, rvalid[1]=1, rdata=0.
- Write of 0xFFFB (-5) to addr 99, then a read of 99 on the next cycle -> rdata=0xFFFB with rvalid one cycle after the read grant.
- Assert reset_n=0 while locked with a read in flight -> rvalid=0 immediately, lock cleared; after release, the first grant follows rr_ptr=0.
